// File: rtl/dac_spi_slave_if.sv
// Bus bundle for dac_spi_slave: SPI/DAC control inputs, decoded frame fields and DAC outputs.
// With DAC_SPI_SLAVE_MISO_EN defined the bundle also carries the spi_miso echo line.
interface dac_spi_slave_if;
  logic        spi_sck;
  logic        spi_mosi;
  logic        dac_cs;
  logic        dac_clr;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  rx_command;
  logic [3:0]  rx_channel;
  logic [11:0] rx_value;
  logic [11:0] dac_a;
  logic [11:0] dac_b;
  logic [11:0] dac_c;
  logic [11:0] dac_d;
`ifdef DAC_SPI_SLAVE_MISO_EN
  logic        spi_miso;

  modport master (
    output spi_sck, spi_mosi, dac_cs, dac_clr,
    input  frame_valid, frame_err, rx_command, rx_channel, rx_value,
    input  dac_a, dac_b, dac_c, dac_d, spi_miso
  );

  modport slave (
    input  spi_sck, spi_mosi, dac_cs, dac_clr,
    output frame_valid, frame_err, rx_command, rx_channel, rx_value,
    output dac_a, dac_b, dac_c, dac_d, spi_miso
  );
`else
  modport master (
    output spi_sck, spi_mosi, dac_cs, dac_clr,
    input  frame_valid, frame_err, rx_command, rx_channel, rx_value,
    input  dac_a, dac_b, dac_c, dac_d
  );

  modport slave (
    input  spi_sck, spi_mosi, dac_cs, dac_clr,
    output frame_valid, frame_err, rx_command, rx_channel, rx_value,
    output dac_a, dac_b, dac_c, dac_d
  );
`endif
endinterface

// File: rtl/dac_spi_slave.sv
// SPI slave that decodes 32-bit frames into commands for a four-channel 12-bit DAC register bank.
// Optional feature: define DAC_SPI_SLAVE_MISO_EN to echo the previous valid frame on spi_miso.
module dac_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 32
) (
  input  logic           clk,
  input  logic           rst,
  dac_spi_slave_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE} state_t;

  localparam logic [5:0] LP_FRAME_CNT = 6'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_cs_sync, r_clr_sync;
  logic                   r_sck_d, r_cs_d;
  logic                   w_sck, w_mosi, w_cs, w_clr;
  logic                   w_sck_rise, w_cs_fall, w_cs_rise;

  state_t      r_state;
  logic [31:0] r_shift;
  logic [5:0]  r_count;
  logic        r_frame_valid, r_frame_err;
  logic [3:0]  r_rx_command, r_rx_channel;
  logic [11:0] r_rx_value;
  logic [11:0] r_in  [4];
  logic [11:0] r_dac [4];

`ifdef DAC_SPI_SLAVE_MISO_EN
  logic [31:0] r_last;
  logic [31:0] r_tx;
  logic        r_miso;
  logic        w_sck_fall;
  assign w_sck_fall   = !w_sck && r_sck_d;
  assign bus.spi_miso = r_miso;
`else
  logic w_unused_dc;
  assign w_unused_dc = ^{r_shift[31:28], r_shift[7:0]};
`endif

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_clr      = r_clr_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck && !r_sck_d;
  assign w_cs_fall  = !w_cs && r_cs_d;
  assign w_cs_rise  = w_cs && !r_cs_d;

  // Synchronisers reset to the bus idle levels so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_clr_sync  <= '1;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.dac_cs};
      r_clr_sync  <= {r_clr_sync[SYNC_STAGES-2:0], bus.dac_clr};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_count       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_rx_command  <= '0;
      r_rx_channel  <= '0;
      r_rx_value    <= '0;
      for (int i = 0; i < 4; i++) begin
        r_in[i]  <= '0;
        r_dac[i] <= '0;
      end
`ifdef DAC_SPI_SLAVE_MISO_EN
      r_last <= '0;
      r_tx   <= '0;
      r_miso <= 1'b0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef DAC_SPI_SLAVE_MISO_EN
          r_miso <= 1'b0;
`endif
          if (w_cs_fall) begin
            r_state <= S_SHIFT;
            r_shift <= '0;
            r_count <= '0;
`ifdef DAC_SPI_SLAVE_MISO_EN
            r_miso <= r_last[31];
            r_tx   <= {r_last[30:0], 1'b0};
`endif
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            r_state <= S_DECODE;
          end else if (w_sck_rise) begin
            r_shift <= {r_shift[30:0], w_mosi};
            if (r_count != 6'd63) r_count <= r_count + 6'd1;
          end
`ifdef DAC_SPI_SLAVE_MISO_EN
          if (!w_cs_rise && w_sck_fall) begin
            r_miso <= r_tx[31];
            r_tx   <= {r_tx[30:0], 1'b0};
          end
`endif
        end
        S_DECODE: begin
          r_state <= S_IDLE;
`ifdef DAC_SPI_SLAVE_MISO_EN
          r_miso <= 1'b0;
`endif
          if (r_count == LP_FRAME_CNT) begin
            r_frame_valid <= 1'b1;
            r_rx_value    <= r_shift[27:16];
            r_rx_channel  <= r_shift[15:12];
            r_rx_command  <= r_shift[11:8];
`ifdef DAC_SPI_SLAVE_MISO_EN
            r_last <= r_shift;
`endif
            // Channel code F addresses all four channels; undefined codes address none.
            for (int i = 0; i < 4; i++) begin
              if (r_shift[15:12] == 4'(i) || r_shift[15:12] == 4'hF) begin
                case (r_shift[11:8])
                  4'h0: r_in[i] <= r_shift[27:16];
                  4'h1: r_dac[i] <= r_in[i];
                  4'h3: begin
                    r_in[i]  <= r_shift[27:16];
                    r_dac[i] <= r_shift[27:16];
                  end
                  default: ;
                endcase
              end
            end
          end else if (r_count != 6'd0) begin
            r_frame_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Clear wins over any write issued in the same cycle.
      if (!w_clr) begin
        for (int i = 0; i < 4; i++) begin
          r_in[i]  <= '0;
          r_dac[i] <= '0;
        end
      end
    end
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.rx_command  = r_rx_command;
  assign bus.rx_channel  = r_rx_channel;
  assign bus.rx_value    = r_rx_value;
  assign bus.dac_a       = r_dac[0];
  assign bus.dac_b       = r_dac[1];
  assign bus.dac_c       = r_dac[2];
  assign bus.dac_d       = r_dac[3];

endmodule

// File: tb/tb_dac_spi_slave.sv
// Self-checking bench for dac_spi_slave: directed vector table, reset-mid-frame sequence,
// then randomized frames compared against a behavioural model of the DAC register bank.
module tb_dac_spi_slave;
  localparam int SYNC = 2;
  localparam int HALF = 5;

  typedef struct {
    logic [63:0] bits;
    int          n;
    logic        clrLow;
    logic        expValid;
    logic        expErr;
    logic [11:0] expVal;
    logic [3:0]  expCh;
    logic [3:0]  expCmd;
    logic [11:0] expA, expB, expC, expD;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [11:0] mIn [4];
  logic [11:0] mDac [4];
  logic [11:0] mVal;
  logic [3:0]  mCh, mCmd;
  logic [31:0] mLast;

  dac_spi_slave_if bus();

  dac_spi_slave #(.SYNC_STAGES(SYNC), .FRAME_BITS(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [63:0] mk(input logic [11:0] val, input logic [3:0] ch, input logic [3:0] cmd);
    return {32'h0, 4'h0, val, ch, cmd, 8'h00};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mIn[i]  = '0;
      mDac[i] = '0;
    end
    mVal  = '0;
    mCh   = '0;
    mCmd  = '0;
    mLast = '0;
  endtask

  // Frame-level model: a full 32-bit frame updates fields and executes, other non-zero counts error.
  task automatic modelDecode(input logic [63:0] bits, input int n, input logic clrOn,
                             output logic eV, output logic eE);
    logic [31:0] f;
    f  = bits[31:0];
    eV = 1'b0;
    eE = 1'b0;
    if (n == 32) begin
      eV    = 1'b1;
      mVal  = f[27:16];
      mCh   = f[15:12];
      mCmd  = f[11:8];
      mLast = f;
      for (int i = 0; i < 4; i++) begin
        if (mCh == 4'(i) || mCh == 4'hF) begin
          if (mCmd == 4'h1) mDac[i] = mIn[i];
          if (mCmd == 4'h0 || mCmd == 4'h3) mIn[i] = mVal;
          if (mCmd == 4'h3) mDac[i] = mVal;
        end
      end
    end else if (n != 0) begin
      eE = 1'b1;
    end
    if (clrOn) begin
      for (int i = 0; i < 4; i++) begin
        mIn[i]  = '0;
        mDac[i] = '0;
      end
    end
  endtask

  task automatic shiftBits(input logic [63:0] bits, input int n, output logic [31:0] misoSeen);
    misoSeen = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_mosi = bits[i];
      repeat (HALF) @(negedge clk);
`ifdef DAC_SPI_SLAVE_MISO_EN
      if (n - 1 - i < 32) misoSeen[31 - (n - 1 - i)] = bus.spi_miso;
`endif
      bus.spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [63:0] bits, input int n, input logic clrLow,
                               output int vCnt, output int eCnt, output int vLat, output int eLat,
                               output logic [31:0] misoSeen);
    vCnt = 0;
    eCnt = 0;
    vLat = -1;
    eLat = -1;
    if (clrLow) bus.dac_clr = 1'b0;
    bus.dac_cs = 1'b0;
    repeat (8) @(negedge clk);
    shiftBits(bits, n, misoSeen);
    repeat (HALF) @(negedge clk);
    bus.dac_cs = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.frame_valid) begin
        vCnt++;
        if (vLat < 0) vLat = k;
      end
      if (bus.frame_err) begin
        eCnt++;
        if (eLat < 0) eLat = k;
      end
    end
    if (clrLow) begin
      bus.dac_clr = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  // Pulse latency counts negedges after the cs rise; the first posedge sampling cs high precedes k=1.
  task automatic frameChecks(input string tag, input int vCnt, input int eCnt, input int vLat, input int eLat,
                             input logic expV, input logic expE, input logic [11:0] val,
                             input logic [3:0] ch, input logic [3:0] cmd,
                             input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] d);
    checkOutput({tag, "_valid_count"}, 64'(vCnt), expV ? 64'd1 : 64'd0);
    checkOutput({tag, "_err_count"}, 64'(eCnt), expE ? 64'd1 : 64'd0);
    if (expV) checkOutput({tag, "_valid_latency"}, 64'(vLat), 64'(SYNC + 2));
    if (expE) checkOutput({tag, "_err_latency"}, 64'(eLat), 64'(SYNC + 2));
    checkOutput({tag, "_rx_value"}, 64'(bus.rx_value), 64'(val));
    checkOutput({tag, "_rx_channel"}, 64'(bus.rx_channel), 64'(ch));
    checkOutput({tag, "_rx_command"}, 64'(bus.rx_command), 64'(cmd));
    checkOutput({tag, "_dac_a"}, 64'(bus.dac_a), 64'(a));
    checkOutput({tag, "_dac_b"}, 64'(bus.dac_b), 64'(b));
    checkOutput({tag, "_dac_c"}, 64'(bus.dac_c), 64'(c));
    checkOutput({tag, "_dac_d"}, 64'(bus.dac_d), 64'(d));
`ifdef DAC_SPI_SLAVE_MISO_EN
    checkOutput({tag, "_miso_idle"}, 64'(bus.spi_miso), 64'd0);
`endif
  endtask

  task automatic misoCheck(input string tag, input int n, input logic [31:0] seen, input logic [31:0] prev);
`ifdef DAC_SPI_SLAVE_MISO_EN
    if (n >= 32) checkOutput({tag, "_miso_echo"}, 64'(seen), 64'(prev));
`else
    if (n < 0) $display("[TB] %s %0h %0h", tag, seen, prev);
`endif
  endtask

  vec_t        vecs [13];
  int          vCnt, eCnt, vLat, eLat;
  logic        eV, eE;
  logic [31:0] misoSeen, prevLast;

  initial begin
    vecs[0]  = '{mk(12'hABC, 4'h1, 4'h3), 32, 1'b0, 1'b1, 1'b0, 12'hABC, 4'h1, 4'h3, 12'h000, 12'hABC, 12'h000, 12'h000};
    vecs[1]  = '{mk(12'h123, 4'hF, 4'h0), 32, 1'b0, 1'b1, 1'b0, 12'h123, 4'hF, 4'h0, 12'h000, 12'hABC, 12'h000, 12'h000};
    vecs[2]  = '{{32'h0, 4'hA, 12'h777, 4'h2, 4'h1, 8'h5A}, 32, 1'b0, 1'b1, 1'b0, 12'h777, 4'h2, 4'h1, 12'h000, 12'hABC, 12'h123, 12'h000};
    vecs[3]  = '{64'h0000_0000_7FFF_FFFF, 31, 1'b0, 1'b0, 1'b1, 12'h777, 4'h2, 4'h1, 12'h000, 12'hABC, 12'h123, 12'h000};
    vecs[4]  = '{64'h0000_0001_2345_6789, 33, 1'b0, 1'b0, 1'b1, 12'h777, 4'h2, 4'h1, 12'h000, 12'hABC, 12'h123, 12'h000};
    vecs[5]  = '{64'h0, 0, 1'b0, 1'b0, 1'b0, 12'h777, 4'h2, 4'h1, 12'h000, 12'hABC, 12'h123, 12'h000};
    vecs[6]  = '{mk(12'hFFF, 4'hF, 4'h3), 32, 1'b1, 1'b1, 1'b0, 12'hFFF, 4'hF, 4'h3, 12'h000, 12'h000, 12'h000, 12'h000};
    vecs[7]  = '{mk(12'h999, 4'h0, 4'h7), 32, 1'b0, 1'b1, 1'b0, 12'h999, 4'h0, 4'h7, 12'h000, 12'h000, 12'h000, 12'h000};
    vecs[8]  = '{mk(12'h111, 4'h5, 4'h3), 32, 1'b0, 1'b1, 1'b0, 12'h111, 4'h5, 4'h3, 12'h000, 12'h000, 12'h000, 12'h000};
    vecs[9]  = '{mk(12'h222, 4'h1, 4'hF), 32, 1'b0, 1'b1, 1'b0, 12'h222, 4'h1, 4'hF, 12'h000, 12'h000, 12'h000, 12'h000};
    vecs[10] = '{mk(12'h555, 4'h0, 4'h3), 32, 1'b0, 1'b1, 1'b0, 12'h555, 4'h0, 4'h3, 12'h555, 12'h000, 12'h000, 12'h000};
    vecs[11] = '{mk(12'h456, 4'h3, 4'h0), 32, 1'b0, 1'b1, 1'b0, 12'h456, 4'h3, 4'h0, 12'h555, 12'h000, 12'h000, 12'h000};
    vecs[12] = '{mk(12'h000, 4'h3, 4'h1), 32, 1'b0, 1'b1, 1'b0, 12'h000, 4'h3, 4'h1, 12'h555, 12'h000, 12'h000, 12'h456};

    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.dac_cs   = 1'b1;
    bus.dac_clr  = 1'b1;
    modelReset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_frame_valid", 64'(bus.frame_valid), 64'd0);
    checkOutput("reset_frame_err", 64'(bus.frame_err), 64'd0);
    checkOutput("reset_rx_value", 64'(bus.rx_value), 64'd0);
    checkOutput("reset_dac_a", 64'(bus.dac_a), 64'd0);
    checkOutput("reset_dac_d", 64'(bus.dac_d), 64'd0);
`ifdef DAC_SPI_SLAVE_MISO_EN
    checkOutput("reset_miso", 64'(bus.spi_miso), 64'd0);
`endif
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      prevLast = mLast;
      modelDecode(vecs[v].bits, vecs[v].n, vecs[v].clrLow, eV, eE);
      applyStimulus(vecs[v].bits, vecs[v].n, vecs[v].clrLow, vCnt, eCnt, vLat, eLat, misoSeen);
      frameChecks($sformatf("vec%0d", v), vCnt, eCnt, vLat, eLat, vecs[v].expValid, vecs[v].expErr,
                  vecs[v].expVal, vecs[v].expCh, vecs[v].expCmd,
                  vecs[v].expA, vecs[v].expB, vecs[v].expC, vecs[v].expD);
      misoCheck($sformatf("vec%0d", v), vecs[v].n, misoSeen, prevLast);
    end

    begin : reset_mid_frame
      logic [63:0] partial;
      int          pulses;
      partial = 64'h0000_0000_0000_BEEF;
      bus.dac_cs = 1'b0;
      repeat (8) @(negedge clk);
      shiftBits(partial, 16, misoSeen);
      rst        = 1'b0;
      bus.dac_cs = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      modelReset();
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (bus.frame_valid || bus.frame_err) pulses++;
      end
      checkOutput("rst_partial_pulses", 64'(pulses), 64'd0);
      checkOutput("rst_dac_a", 64'(bus.dac_a), 64'd0);
      checkOutput("rst_dac_d", 64'(bus.dac_d), 64'd0);
      checkOutput("rst_rx_value", 64'(bus.rx_value), 64'd0);
      prevLast = mLast;
      modelDecode(mk(12'h555, 4'h0, 4'h3), 32, 1'b0, eV, eE);
      applyStimulus(mk(12'h555, 4'h0, 4'h3), 32, 1'b0, vCnt, eCnt, vLat, eLat, misoSeen);
      frameChecks("rst_after", vCnt, eCnt, vLat, eLat, 1'b1, 1'b0, 12'h555, 4'h0, 4'h3,
                  12'h555, 12'h000, 12'h000, 12'h000);
      misoCheck("rst_after", 32, misoSeen, prevLast);
    end

    for (int r = 0; r < 24; r++) begin
      logic [63:0] bits;
      int          n, sel;
      logic        clrOn;
      bits = {$urandom, $urandom};
      sel  = int'($urandom_range(0, 9));
      n    = (sel <= 6) ? 32 : (sel == 7) ? 0 : int'($urandom_range(1, 40));
      case ($urandom_range(0, 4))
        0: bits[11:8] = 4'h0;
        1: bits[11:8] = 4'h1;
        2: bits[11:8] = 4'h3;
        3: bits[11:8] = 4'hF;
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0: bits[15:12] = 4'hF;
        1: bits[15:12] = 4'($urandom_range(0, 3));
        default: ;
      endcase
      clrOn    = ($urandom_range(0, 7) == 0);
      prevLast = mLast;
      modelDecode(bits, n, clrOn, eV, eE);
      applyStimulus(bits, n, clrOn, vCnt, eCnt, vLat, eLat, misoSeen);
      frameChecks($sformatf("rand%0d", r), vCnt, eCnt, vLat, eLat, eV, eE, mVal, mCh, mCmd,
                  mDac[0], mDac[1], mDac[2], mDac[3]);
      misoCheck($sformatf("rand%0d", r), n, misoSeen, prevLast);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_slave.md
DAC_SPI_SLAVE -- requirements
Module: dac_spi_slave

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchroniser depth for spi_sck, spi_mosi, dac_cs and dac_clr (minimum 2).
REQ-002 Parameter: FRAME_BITS, 32, required bit count of a valid frame.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 spi_sck  in  1  SPI clock from the master; idle low; data sampled on its rising edge.
REQ-007 spi_mosi  in  1  serial data, MSB first.
REQ-008 dac_cs  in  1  chip select, active-low; frame ends on its rising edge.
REQ-009 dac_clr  in  1  active-low clear request.
REQ-010 frame_valid  out  1  one-cycle pulse when a well-formed frame has been decoded.
REQ-011 frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than 0 or FRAME_BITS.
REQ-012 rx_command / rx_channel / rx_value  out  4/4/12  fields of the last valid frame.
REQ-013 dac_a, dac_b, dac_c, dac_d  out  12 each  DAC output registers for channels 0..3.

Function
REQ-014 spi_sck, spi_mosi, dac_cs and dac_clr SHALL each pass through SYNC_STAGES flip-flops before use; clk SHALL run at least 4x the spi_sck rate.
REQ-015 The synchronised frame layout SHALL be: bits 31:28 don't care, 27:16 value, 15:12 channel, 11:8 command, 7:0 don't care.
REQ-016 FSM states: IDLE (cs high), SHIFT (cs low), DECODE (one cycle after cs rise).
REQ-017 IDLE->SHIFT on a synchronised cs falling edge, which also clears the 32-bit shift register and the bit counter.
REQ-018 In SHIFT, each synchronised sck rising edge SHALL shift in mosi at bit 0 and increment the 6-bit bit counter, saturating at 63.
REQ-019 SHIFT->DECODE on a synchronised cs rising edge; DECODE->IDLE unconditionally.
REQ-020 In DECODE with count == FRAME_BITS: pulse frame_valid, load the rx_* fields, and execute the command.
REQ-021 In DECODE with count == 0: no pulse and no register change.
REQ-022 In DECODE with any other count: pulse frame_err only; rx_* and all channel registers stay unchanged.
REQ-023 frame_valid/frame_err SHALL assert exactly SYNC_STAGES+1 clk cycles after the first clk edge that samples dac_cs high.
REQ-024 Each channel SHALL hold a 12-bit input register and a 12-bit DAC register; dac_a..d reflect the DAC registers.
REQ-025 Command 0000: write the input register. 0001: copy input to DAC register. 0011: write both. 1111: no-op. All other codes: no-op, with frame_valid still pulsed.
REQ-026 Channel 0000..0011 selects A..D, 1111 selects all four, and any other code selects none.
REQ-027 While synchronised dac_clr is low, all input and DAC registers SHALL be held at 0; clear overrides a simultaneous DECODE write, but rx_* and frame_valid still update.
REQ-028 A cs rise with no preceding cs fall (the block already in IDLE) SHALL be ignored.

Reset
REQ-029 With rst low at a clk edge, the FSM SHALL go to IDLE and the shift register, counter, rx_*, channel registers, dac_a..d, frame_valid and frame_err SHALL all be 0; synchroniser flops reset to idle levels (sck 0, cs 1, clr 1, mosi 0).
REQ-030 Reset mid-frame SHALL discard the partial frame; the first frame decoded after reset starts at the next cs falling edge.

Configuration
REQ-031 With macro DAC_SPI_SLAVE_MISO_EN defined, output spi_miso (1 bit) SHALL exist and echo the previous valid frame MSB first, updated on each synchronised sck falling edge during SHIFT; it SHALL be 0 in IDLE and after reset.
REQ-032 Without DAC_SPI_SLAVE_MISO_EN, port spi_miso and its echo register SHALL be absent.

Verification
REQ-033 Frame {4'h0,12'hABC,4'h1,4'h3,8'h00} -> frame_valid one pulse; rx_value=ABC, rx_channel=1, rx_command=3; dac_b=ABC; others 0.
REQ-034 Frame cmd 0 ch F value 123, then cmd 1 ch 2 -> dac_a..d remain 0 after the first frame; dac_c=123 after the second.
REQ-035 A 31-bit frame, then a 33-bit frame -> two frame_err pulses, no frame_valid, all registers unchanged.
REQ-036 dac_clr low during a cmd 3 ch F value FFF frame -> dac_a..d=0, frame_valid pulsed, rx_value=FFF.
REQ-037 rst low after 16 bits, released, then a full cmd 3 ch 0 value 555 frame -> no pulse for the partial frame; dac_a=555.
REQ-038 With DAC_SPI_SLAVE_MISO_EN, frame 1 value ABC then frame 2 -> spi_miso during frame 2 equals frame 1's 32 bits, MSB first.
